// File: rtl/writeback_queue_pkg.sv
// writeback_queue_pkg
//   Shared widths and entry type for the writeback path. Used by the
//   writeback queue and the 8x19 register file it feeds.
package writeback_queue_pkg;

  localparam int DATA_W    = 19;  // register data width
  localparam int ADDR_W    = 3;   // register index width (8 registers)
  localparam int WBQ_DEPTH = 4;   // pending-write FIFO depth
  localparam int PTR_W     = 2;   // FIFO pointer width, wraps modulo WBQ_DEPTH
  localparam int CNT_W     = 3;   // occupancy width, holds 0..WBQ_DEPTH

  // One pending register write.
  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wbq_entry_t;

  // Identifies which result source won the last accepted transfer.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wbq_src_e;

endpackage

// File: rtl/wbq_rr_arbiter.sv
// wbq_rr_arbiter
//   Two-source round-robin grant for the writeback queue. A lone requester
//   is always granted; on a tie the source that did not win the last
//   accepted transfer wins. The history only advances on an accepted
//   transfer, so a stalled grant stays put.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   req_alu, req_mem     source requests (valid)
//   accept               a granted request was transferred this cycle
//   grant_alu, grant_mem combinational grants, at most one high
module wbq_rr_arbiter
  import writeback_queue_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_alu,
  input  logic req_mem,
  input  logic accept,
  output logic grant_alu,
  output logic grant_mem
);

  wbq_src_e last_src_q, last_src_d;

  always_comb begin
    grant_alu  = req_alu && (!req_mem || (last_src_q == SRC_MEM));
    grant_mem  = req_mem && (!req_alu || (last_src_q == SRC_ALU));
    last_src_d = last_src_q;
    if (accept) begin
      last_src_d = grant_alu ? SRC_ALU : SRC_MEM;
    end
  end

  // Reset pretends MEM won last so that ALU is favoured on the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_src_q <= SRC_MEM;
    end else begin
      last_src_q <= last_src_d;
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// writeback_queue
//   4-entry FIFO of pending register writes fed by an ALU and a memory
//   result source, drained in order into the register file write port,
//   with a bypass lookup of the pending writes.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   alu_valid/alu_dest/alu_data/alu_ready  ALU result handshake
//   mem_valid/mem_dest/mem_data/mem_ready  memory result handshake
//   wb_hold                             stalls draining while high
//   r3/write_data/register_write        register file write port (head entry)
//   fwd_addr/fwd_hit/fwd_data           bypass lookup, youngest match wins
//   count/full/empty                    occupancy status
module writeback_queue
  import writeback_queue_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              wb_hold,
  output logic [ADDR_W-1:0] r3,
  output logic [DATA_W-1:0] write_data,
  output logic              register_write,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  wbq_entry_t       entry_q [WBQ_DEPTH];

  logic       grant_alu, grant_mem;
  logic       space, enq, deq, alu_fire, mem_fire;
  wbq_entry_t new_entry, head;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(WBQ_DEPTH));

  // Write port: head entry, zeroed when nothing is pending.
  assign head           = entry_q[rd_ptr_q];
  assign register_write = !empty && !wb_hold;
  assign r3             = empty ? '0 : head.dest;
  assign write_data     = empty ? '0 : head.data;
  assign deq            = register_write;

  // A full queue still has room when the head leaves this same edge.
  // Readys are forced low while reset is held.
  assign space = !reset && (!full || deq);

  wbq_rr_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_alu   (alu_valid),
    .req_mem   (mem_valid),
    .accept    (enq),
    .grant_alu (grant_alu),
    .grant_mem (grant_mem)
  );

  assign alu_ready = space && grant_alu;
  assign mem_ready = space && grant_mem;
  assign alu_fire  = alu_valid && alu_ready;
  assign mem_fire  = mem_valid && mem_ready;
  assign enq       = alu_fire || mem_fire;
  assign new_entry = alu_fire ? wbq_entry_t'({alu_dest, alu_data})
                              : wbq_entry_t'({mem_dest, mem_data});

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (enq && !deq) count_d = count_q + CNT_W'(1);
    if (deq && !enq) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy is derived from count/pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_q[wr_ptr_q] <= new_entry;
    end
  end

  // Per-slot match: a slot is occupied when its age from the head is below
  // count. Only already-stored entries are seen, never this cycle's enqueue.
  logic [WBQ_DEPTH-1:0] slot_hit;
  genvar gi;
  generate
    for (gi = 0; gi < WBQ_DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] age;
      assign age          = PTR_W'(gi) - rd_ptr_q;
      assign slot_hit[gi] = ({1'b0, age} < count_q) && (entry_q[gi].dest == fwd_addr);
    end
  endgenerate

  // Walk oldest to youngest so the youngest match is the one left standing.
  logic [PTR_W-1:0] fwd_idx;
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < WBQ_DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PTR_W'(k);
      if (slot_hit[fwd_idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_q[fwd_idx].data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid, mem_valid, wb_hold;
  logic [ADDR_W-1:0] alu_dest, mem_dest, fwd_addr, r3;
  logic [DATA_W-1:0] alu_data, mem_data, write_data, fwd_data;
  logic              alu_ready, mem_ready, register_write, fwd_hit, full, empty;
  logic [CNT_W-1:0]  count;

  always #5 clk = ~clk;

  writeback_queue dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_hold(wb_hold),
    .r3(r3), .write_data(write_data), .register_write(register_write),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .full(full), .empty(empty)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: an ordered list of pending writes plus whose turn a tie is.
  typedef struct { int dest; int data; } ent_t;
  ent_t mq[$];
  bit   alu_turn;
  int   acc_log[$];      // 0 = ALU accepted, 1 = MEM accepted (observed on DUT)
  int   wr_dest_log[$];
  int   wr_data_log[$];
  int   max_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    alu_turn = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rw"},    register_write, 0);
    check({pfx, "_r3"},    r3, 0);
    check({pfx, "_wd"},    write_data, 0);
    check({pfx, "_fhit"},  fwd_hit, 0);
    check({pfx, "_fdata"}, fwd_data, 0);
    check({pfx, "_ardy"},  alu_ready, 0);
    check({pfx, "_mrdy"},  mem_ready, 0);
    check({pfx, "_count"}, count, 0);
    check({pfx, "_full"},  full, 0);
    check({pfx, "_empty"}, empty, 1);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    mem_valid = 0; mem_dest = 0; mem_data = 0;
    wb_hold = 0; fwd_addr = 0;
  endtask

  // Reset pulse with both sources requesting: readys must stay low throughout.
  task automatic pulse_reset(input string pfx);
    @(negedge clk);
    #2;
    alu_valid = 1; mem_valid = 1;
    reset = 1;
    #1;
    model_clear();
    check_reset_outputs(pfx);
    @(negedge clk);
    idle_inputs();
    reset = 0;
  endtask

  // One clock of stimulus, checked against the model before the edge.
  task automatic cycle(input logic av, input int ad, input int adat,
                       input logic mv, input int md, input int mdat,
                       input logic hold, input int fa);
    int  n;
    bit  deq, space, ga, gm, ehit;
    int  edata, er3, ewd;
    @(negedge clk);
    alu_valid = av; alu_dest = ADDR_W'(ad); alu_data = DATA_W'(adat);
    mem_valid = mv; mem_dest = ADDR_W'(md); mem_data = DATA_W'(mdat);
    wb_hold = hold; fwd_addr = ADDR_W'(fa);
    #1;
    n     = mq.size();
    deq   = (n > 0) && !hold;
    space = (n < 4) || deq;
    ga    = av && (!mv || alu_turn);
    gm    = mv && (!av || !alu_turn);
    er3   = (n > 0) ? mq[0].dest : 0;
    ewd   = (n > 0) ? mq[0].data : 0;
    ehit  = 0; edata = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!ehit && mq[i].dest == fa) begin
        ehit = 1; edata = mq[i].data;
      end
    end
    check("ardy",  alu_ready, space && ga);
    check("mrdy",  mem_ready, space && gm);
    check("rw",    register_write, deq);
    check("r3",    r3, er3);
    check("wd",    write_data, ewd);
    check("fhit",  fwd_hit, ehit);
    check("fdata", fwd_data, edata);
    check("count", count, n);
    check("full",  full, n == 4);
    check("empty", empty, n == 0);
    // Observed-traffic logs for directed ordering checks.
    if (alu_valid && alu_ready) acc_log.push_back(0);
    if (mem_valid && mem_ready) acc_log.push_back(1);
    if (register_write) begin
      wr_dest_log.push_back(int'(r3));
      wr_data_log.push_back(int'(write_data));
    end
    if (int'(count) > max_count) max_count = int'(count);
    // Advance the model to what the coming edge should do.
    if (deq) void'(mq.pop_front());
    if (space && ga) begin
      mq.push_back('{ad, adat}); alu_turn = 0;
    end else if (space && gm) begin
      mq.push_back('{md, mdat}); alu_turn = 1;
    end
  endtask

  task automatic idle(input logic hold, input int fa);
    cycle(0, 0, 0, 0, 0, 0, hold, fa);
  endtask

  initial begin
    idle_inputs();
    alu_valid = 1; mem_valid = 1;
    reset = 1;
    model_clear();
    max_count = 0;
    #2;
    check_reset_outputs("rst0");
    @(negedge clk);
    idle_inputs();
    reset = 0;

    // Single write through the queue.
    cycle(1, 5, 'h1ABCD, 0, 0, 0, 0, 0);
    check("single_ardy", alu_ready, 1);
    idle(0, 0);
    check("single_rw", register_write, 1);
    check("single_r3", r3, 5);
    check("single_wd", write_data, 'h1ABCD);
    idle(0, 0);
    check("single_empty", empty, 1);

    // Round-robin arbitration filling the queue while held.
    pulse_reset("rst1");
    acc_log.delete();
    for (int i = 0; i < 4; i++) cycle(1, 1, 'h100 + i, 1, 2, 'h200 + i, 1, 0);
    cycle(1, 1, 'h1FF, 1, 2, 'h2FF, 1, 0);
    check("arb_ardy5", alu_ready, 0);
    check("arb_mrdy5", mem_ready, 0);
    check("arb_full",  full, 1);
    check("arb_count", count, 4);
    check("arb_nacc",  acc_log.size(), 4);
    if (acc_log.size() == 4) begin
      check("arb_ord0", acc_log[0], 0);
      check("arb_ord1", acc_log[1], 1);
      check("arb_ord2", acc_log[2], 0);
      check("arb_ord3", acc_log[3], 1);
    end

    // Full with a same-cycle drain still accepts.
    cycle(0, 0, 0, 1, 6, 'h300, 0, 0);
    check("drain_rw",   register_write, 1);
    check("drain_mrdy", mem_ready, 1);
    idle(1, 6);
    check("drain_count", count, 4);
    check("drain_fwd",   fwd_data, 'h300);

    // Forwarding: youngest match, miss, and no forward of this cycle's enqueue.
    pulse_reset("rst2");
    cycle(1, 2, 'h11, 0, 0, 0, 1, 0);
    cycle(1, 2, 'h22, 0, 0, 0, 1, 0);
    idle(1, 2);
    check("fwd_hit2",  fwd_hit, 1);
    check("fwd_data2", fwd_data, 'h22);
    idle(1, 3);
    check("fwd_hit3",  fwd_hit, 0);
    check("fwd_data3", fwd_data, 0);
    cycle(1, 4, 'h44, 0, 0, 0, 1, 4);
    check("fwd_enq_hit", fwd_hit, 0);
    check("fwd_pending", count, 2);
    idle(1, 0);
    check("fwd_three", count, 3);

    // Asynchronous reset mid-operation with three pending entries.
    @(negedge clk);
    #3;
    alu_valid = 1;
    reset = 1;
    #1;
    model_clear();
    check_reset_outputs("rst_mid");
    @(negedge clk);
    idle_inputs();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      idle(0, 0);
      check("post_rst_rw", register_write, 0);
    end

    // Wrap-around with continuous drain.
    pulse_reset("rst3");
    wr_dest_log.delete(); wr_data_log.delete(); max_count = 0;
    for (int i = 0; i < 10; i++) cycle(1, i % 8, 'h1000 + i, 0, 0, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    check("wrap_nwr", wr_dest_log.size(), 10);
    if (wr_dest_log.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        check("wrap_dest", wr_dest_log[i], i % 8);
        check("wrap_data", wr_data_log[i], 'h1000 + i);
      end
    end
    check("wrap_maxcnt", max_count <= 1, 1);

    // Randomized traffic against the model.
    pulse_reset("rst4");
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 'h7FFFF)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 'h7FFFF)),
            1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports alu_valid input 1, alu_dest input 3, alu_data input 19, alu_ready output 1: ALU result source handshake.
REQ-004 SHALL have ports mem_valid input 1, mem_dest input 3, mem_data input 19, mem_ready output 1: load/memory result source handshake.
REQ-005 SHALL have port wb_hold  input  1  freezes draining to the register file while high.
REQ-006 SHALL have ports r3 output 3, write_data output 19, register_write output 1: register file write port (drives r3/write_data/register_write of the 8x19 register file).
REQ-007 SHALL have ports fwd_addr input 3, fwd_hit output 1, fwd_data output 19: bypass lookup of pending writes.
REQ-008 SHALL have ports count output 3 (0..4), full output 1, empty output 1: occupancy status.

Function
REQ-009 SHALL hold pending writes in a 4-entry FIFO; entry = {dest[2:0], data[18:0]}; head = oldest.
REQ-010 SHALL enqueue at most one entry per cycle; a transfer occurs on a source when valid && ready at rising clk.
REQ-011 SHALL define space = (count < 4) || dequeue-this-cycle; enqueue into a full FIFO with a same-cycle dequeue is legal.
REQ-012 SHALL grant ALU when only alu_valid, MEM when only mem_valid; when both valid, grant the source not granted on the last accepted transfer (round-robin).
REQ-013 SHALL drive alu_ready = space && grant_alu and mem_ready = space && grant_mem, combinationally; at most one ready high per cycle.
REQ-014 SHALL update the round-robin pointer only on an accepted transfer; sources SHALL NOT make valid depend on ready.
REQ-015 SHALL drive register_write = !empty && !wb_hold combinationally; r3/write_data = head entry; head is dequeued at the edge where register_write is high.
REQ-016 SHALL drive r3 and write_data to 0 when empty.
REQ-017 SHALL provide a minimum enqueue-to-register_write latency of 1 cycle (entry accepted at edge N visible on the write port in cycle N+1).
REQ-018 SHALL update count by +1 on enqueue only, -1 on dequeue only, unchanged on both or neither; full = (count==4), empty = (count==0).
REQ-019 SHALL wrap 2-bit read and write pointers modulo 4.
REQ-020 SHALL assert fwd_hit combinationally when any occupied entry (including the head being written this cycle) has dest == fwd_addr; fwd_data = data of the youngest matching entry, else 0.
REQ-021 SHALL NOT forward an entry being enqueued in the current cycle.
REQ-022 SHALL allow duplicate dest entries; writes commit strictly in FIFO order (last write wins in the register file).
REQ-023 SHALL accept no transfer and keep both readys low when full and no dequeue occurs (e.g. wb_hold high).

Reset
REQ-024 SHALL, on reset assertion and independent of clk, clear count, pointers and all entry valid state; round-robin pointer favours ALU.
REQ-025 SHALL hold during reset: register_write 0, r3 0, write_data 0, fwd_hit 0, fwd_data 0, alu_ready 0, mem_ready 0, count 0, full 0, empty 1.
REQ-026 SHALL discard all pending entries on reset asserted mid-operation; no register_write pulse after deassertion until a new transfer.

Structure
REQ-027 SHALL place DATA_W=19, ADDR_W=3, WBQ_DEPTH=4 and the entry type {dest,data} in a shared package used by the register file and this block.
REQ-028 SHALL implement the 2-source round-robin grant in one sub-module, wbq_rr_arbiter (inputs req_alu, req_mem, accept; outputs grant_alu, grant_mem).

Verification
REQ-029 Single write: alu_valid, dest 5, data 0x1ABCD -> alu_ready 1; next cycle register_write 1, r3 5, write_data 0x1ABCD; empty 1 after.
REQ-030 Arbitration: alu and mem both valid 4 cycles, wb_hold 1 -> accept order ALU,MEM,ALU,MEM; full 1, count 4; fifth cycle both readys 0.
REQ-031 Full with drain: FIFO full, wb_hold 0, mem_valid -> register_write 1 and mem_ready 1 same cycle; count stays 4.
REQ-032 Forwarding: queue dest 2 data 0x00011 then dest 2 data 0x00022, wb_hold 1, fwd_addr 2 -> fwd_hit 1, fwd_data 0x00022; fwd_addr 3 -> fwd_hit 0, fwd_data 0.
REQ-033 Reset mid-operation: 3 entries pending, reset pulsed asynchronously between edges -> outputs per REQ-025 immediately; no register_write after release.
REQ-034 Wrap-around: 10 back-to-back ALU writes dest 0..7,0,1 with continuous drain -> register_write sequence matches input order exactly; count never exceeds 1.
